alu_operand_stage: RTL and testbench

//  ID/EX pipeline stage directly upstream of the ALU. Captures register-file reads, immediate,

---
 rtl/alu_operand_stage_pkg.sv | 22 ++
 rtl/alu_operand_stage_fwd_mux.sv | 43 ++++
 rtl/alu_operand_stage.sv | 133 +++++++++++++
 tb/tb_alu_operand_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_operand_stage_pkg.sv
// Shared definitions for the ID/EX operand stage and the ALU it feeds:
// default widths, ALUSel opcode encodings and the hard-zero register index.
package alu_operand_stage_pkg;

    localparam int unsigned DEFAULT_DATA_W = 32;
    localparam int unsigned DEFAULT_REG_AW = 5;
    localparam int unsigned DEFAULT_SEL_W  = 4;

    // Register x0 always reads as zero and is never a forwarding target.
    localparam int unsigned REG_ZERO = 0;

    // ALUSel encodings, shared with the ALU decoder.
    typedef enum logic [DEFAULT_SEL_W-1:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_sel_e;

endpackage

// File: rtl/alu_operand_stage_fwd_mux.sv
// Operand forwarding mux for one source register.
// Build option OPERAND_FWD_EN: when defined, EX/MEM then MEM/WB results bypass
// the register-file value; when undefined, the register-file value is used
// directly. x0 reads as zero in both builds.
module alu_operand_stage_fwd_mux
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned REG_AW = DEFAULT_REG_AW
) (
    input  logic [REG_AW-1:0] i_idx,
    input  logic [DATA_W-1:0] i_rf,
    input  logic              i_ex_we,
    input  logic [REG_AW-1:0] i_ex_rd,
    input  logic [DATA_W-1:0] i_ex_res,
    input  logic              i_wb_we,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic [DATA_W-1:0] i_wb_data,
    output logic [DATA_W-1:0] o_val
);

`ifndef OPERAND_FWD_EN
    // Writeback ports are intentionally ignored in the non-forwarding build.
    logic w_unused_fwd;
    assign w_unused_fwd = ^{i_ex_we, i_ex_rd, i_ex_res, i_wb_we, i_wb_rd, i_wb_data};
`endif

    // Select the operand value: zero register, then youngest producer, then regfile.
    always_comb begin
        o_val = i_rf;
        if (i_idx == REG_AW'(REG_ZERO)) begin
            o_val = '0;
        end
`ifdef OPERAND_FWD_EN
        else if (i_ex_we && (i_ex_rd == i_idx)) begin
            o_val = i_ex_res;
        end else if (i_wb_we && (i_wb_rd == i_idx)) begin
            o_val = i_wb_data;
        end
`endif
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ID/EX pipeline stage feeding the ALU: registers operands, ALUSel and
// destination/control, forwards from EX/MEM and MEM/WB, and inserts one bubble
// on a load-use hazard. Build option OPERAND_FWD_EN enables forwarding.
module alu_operand_stage
    import alu_operand_stage_pkg::*;
#(
    parameter int unsigned DATA_W = DEFAULT_DATA_W,
    parameter int unsigned REG_AW = DEFAULT_REG_AW,
    parameter int unsigned SEL_W  = DEFAULT_SEL_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              InValid,
    input  logic [DATA_W-1:0] RD1,
    input  logic [DATA_W-1:0] RD2,
    input  logic [DATA_W-1:0] Imm,
    input  logic [REG_AW-1:0] Rs,
    input  logic [REG_AW-1:0] Rt,
    input  logic [REG_AW-1:0] RdIn,
    input  logic              ALUSrc,
    input  logic [SEL_W-1:0]  ALUSelIn,
    input  logic              RegWriteIn,
    input  logic              MemReadIn,
    input  logic              ExMemRegWrite,
    input  logic [REG_AW-1:0] ExMemRd,
    input  logic [DATA_W-1:0] ExMemRes,
    input  logic              MemWbRegWrite,
    input  logic [REG_AW-1:0] MemWbRd,
    input  logic [DATA_W-1:0] MemWbData,
    input  logic              Stall,
    input  logic              Flush,
    output logic [DATA_W-1:0] OP1,
    output logic [DATA_W-1:0] OP2,
    output logic [SEL_W-1:0]  ALUSel,
    output logic [REG_AW-1:0] Rd,
    output logic              RegWrite,
    output logic              MemRead,
    output logic              OutValid,
    output logic              LoadUseStall
);

    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [SEL_W-1:0]  r_alusel;
    logic [REG_AW-1:0] r_rd;
    logic              r_regwrite;
    logic              r_memread;
    logic              r_valid;

    logic [DATA_W-1:0] w_fwd_rs;
    logic [DATA_W-1:0] w_fwd_rt;
    logic [DATA_W-1:0] w_op2;
    logic              w_load_use;
    logic              w_bubble;

    alu_operand_stage_fwd_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rs (
        .i_idx     (Rs),
        .i_rf      (RD1),
        .i_ex_we   (ExMemRegWrite),
        .i_ex_rd   (ExMemRd),
        .i_ex_res  (ExMemRes),
        .i_wb_we   (MemWbRegWrite),
        .i_wb_rd   (MemWbRd),
        .i_wb_data (MemWbData),
        .o_val     (w_fwd_rs)
    );

    alu_operand_stage_fwd_mux #(
        .DATA_W (DATA_W),
        .REG_AW (REG_AW)
    ) u_fwd_rt (
        .i_idx     (Rt),
        .i_rf      (RD2),
        .i_ex_we   (ExMemRegWrite),
        .i_ex_rd   (ExMemRd),
        .i_ex_res  (ExMemRes),
        .i_wb_we   (MemWbRegWrite),
        .i_wb_rd   (MemWbRd),
        .i_wb_data (MemWbData),
        .o_val     (w_fwd_rt)
    );

    // Load in this stage whose destination is a live source of the incoming instruction.
    // Rt only counts when it actually feeds OP2 (ALUSrc=0).
    assign w_load_use = r_valid & r_memread & (r_rd != REG_AW'(REG_ZERO)) & InValid &
                        ((r_rd == Rs) | ((r_rd == Rt) & ~ALUSrc));
    assign w_bubble   = w_load_use | ~InValid;
    assign w_op2      = ALUSrc ? Imm : w_fwd_rt;

    // Stage register: reset/flush clear, stall holds, hazard or no instruction bubbles.
    always_ff @(posedge clk) begin
        if (reset || Flush) begin
            r_op1      <= '0;
            r_op2      <= '0;
            r_alusel   <= '0;
            r_rd       <= '0;
            r_regwrite <= 1'b0;
            r_memread  <= 1'b0;
            r_valid    <= 1'b0;
        end else if (!Stall) begin
            if (w_bubble) begin
                r_op1      <= '0;
                r_op2      <= '0;
                r_alusel   <= '0;
                r_rd       <= '0;
                r_regwrite <= 1'b0;
                r_memread  <= 1'b0;
                r_valid    <= 1'b0;
            end else begin
                r_op1      <= w_fwd_rs;
                r_op2      <= w_op2;
                r_alusel   <= ALUSelIn;
                r_rd       <= RdIn;
                r_regwrite <= RegWriteIn;
                r_memread  <= MemReadIn;
                r_valid    <= 1'b1;
            end
        end
    end

    assign OP1          = r_op1;
    assign OP2          = r_op2;
    assign ALUSel       = r_alusel;
    assign Rd           = r_rd;
    assign RegWrite     = r_regwrite;
    assign MemRead      = r_memread;
    assign OutValid     = r_valid;
    assign LoadUseStall = w_load_use;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed self-checking bench for alu_operand_stage. Expected forwarding
// results follow the OPERAND_FWD_EN build option.
module tb_alu_operand_stage;

    logic        clk;
    logic        reset;
    logic        InValid;
    logic [31:0] RD1, RD2, Imm;
    logic [4:0]  Rs, Rt, RdIn;
    logic        ALUSrc;
    logic [3:0]  ALUSelIn;
    logic        RegWriteIn, MemReadIn;
    logic        ExMemRegWrite;
    logic [4:0]  ExMemRd;
    logic [31:0] ExMemRes;
    logic        MemWbRegWrite;
    logic [4:0]  MemWbRd;
    logic [31:0] MemWbData;
    logic        Stall, Flush;
    logic [31:0] OP1, OP2;
    logic [3:0]  ALUSel;
    logic [4:0]  Rd;
    logic        RegWrite, MemRead, OutValid, LoadUseStall;

    int n_checks = 0;
    int n_pass   = 0;

    alu_operand_stage #(
        .DATA_W (32),
        .REG_AW (5),
        .SEL_W  (4)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .InValid       (InValid),
        .RD1           (RD1),
        .RD2           (RD2),
        .Imm           (Imm),
        .Rs            (Rs),
        .Rt            (Rt),
        .RdIn          (RdIn),
        .ALUSrc        (ALUSrc),
        .ALUSelIn      (ALUSelIn),
        .RegWriteIn    (RegWriteIn),
        .MemReadIn     (MemReadIn),
        .ExMemRegWrite (ExMemRegWrite),
        .ExMemRd       (ExMemRd),
        .ExMemRes      (ExMemRes),
        .MemWbRegWrite (MemWbRegWrite),
        .MemWbRd       (MemWbRd),
        .MemWbData     (MemWbData),
        .Stall         (Stall),
        .Flush         (Flush),
        .OP1           (OP1),
        .OP2           (OP2),
        .ALUSel        (ALUSel),
        .Rd            (Rd),
        .RegWrite      (RegWrite),
        .MemRead       (MemRead),
        .OutValid      (OutValid),
        .LoadUseStall  (LoadUseStall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        reset = 0; InValid = 0; RD1 = '0; RD2 = '0; Imm = '0;
        Rs = '0; Rt = '0; RdIn = '0; ALUSrc = 0; ALUSelIn = '0;
        RegWriteIn = 0; MemReadIn = 0;
        ExMemRegWrite = 0; ExMemRd = '0; ExMemRes = '0;
        MemWbRegWrite = 0; MemWbRd = '0; MemWbData = '0;
        Stall = 0; Flush = 0;
    endtask

    task automatic test_reset();
        reset = 1; InValid = $urandom_range(0, 1); RD1 = $urandom; RD2 = $urandom;
        Imm = $urandom; Rs = 5'($urandom); Rt = 5'($urandom); RdIn = 5'($urandom);
        ALUSrc = $urandom_range(0, 1); ALUSelIn = 4'($urandom);
        RegWriteIn = 1; MemReadIn = 1; Stall = $urandom_range(0, 1); Flush = 0;
        ExMemRegWrite = 1; ExMemRd = 5'($urandom); ExMemRes = $urandom;
        MemWbRegWrite = 1; MemWbRd = 5'($urandom); MemWbData = $urandom;
        tick();
        tick();
        n_checks++;
        if ({OP1, OP2, ALUSel, Rd, RegWrite, MemRead, OutValid, LoadUseStall} !== '0)
            $display("FAIL reset_outputs: got OP1=%h OP2=%h ALUSel=%h Rd=%0d RW=%b MR=%b V=%b LUS=%b, want all 0",
                     OP1, OP2, ALUSel, Rd, RegWrite, MemRead, OutValid, LoadUseStall);
        else n_pass++;
        clear_inputs();
    endtask

    task automatic test_capture();
        clear_inputs();
        tick();
        InValid = 1; RD1 = 32'd10; RD2 = 32'd15; Rs = 5'd1; Rt = 5'd2; RdIn = 5'd7;
        ALUSrc = 0; ALUSelIn = 4'b0010; RegWriteIn = 1;
        tick();
        n_checks++;
        if ({OP1, OP2, ALUSel, Rd, RegWrite, MemRead, OutValid} !== {32'd10, 32'd15, 4'd2, 5'd7, 1'b1, 1'b0, 1'b1})
            $display("FAIL capture_reg: got OP1=%0d OP2=%0d ALUSel=%0d Rd=%0d RW=%b MR=%b V=%b, want 10 15 2 7 1 0 1",
                     OP1, OP2, ALUSel, Rd, RegWrite, MemRead, OutValid);
        else n_pass++;
        ALUSrc = 1; Imm = -32'sd4;
        tick();
        n_checks++;
        if ({OP1, OP2} !== {32'd10, 32'hFFFF_FFFC})
            $display("FAIL capture_imm: got OP1=%h OP2=%h, want 0000000a fffffffc", OP1, OP2);
        else n_pass++;
        n_checks++;
        if (LoadUseStall !== 1'b0)
            $display("FAIL capture_no_lus: got %b, want 0", LoadUseStall);
        else n_pass++;
    endtask

    task automatic test_forward();
        logic [31:0] exp_both;
        logic [31:0] exp_wb1, exp_wb2;
        clear_inputs();
        tick();
        InValid = 1; Rs = 5'd3; Rt = 5'd3; RD1 = 32'd11; RD2 = 32'd22; RdIn = 5'd9;
        RegWriteIn = 1; ALUSelIn = 4'b0010;
        ExMemRegWrite = 1; ExMemRd = 5'd3; ExMemRes = 32'd100;
        MemWbRegWrite = 1; MemWbRd = 5'd3; MemWbData = 32'd7;
`ifdef OPERAND_FWD_EN
        exp_both = 32'd100; exp_wb1 = 32'd7; exp_wb2 = 32'd7;
`else
        exp_both = 32'd11;  exp_wb1 = 32'd11; exp_wb2 = 32'd22;
`endif
        tick();
        n_checks++;
        if ({OP1, OP2} !== {exp_both, (exp_both == 32'd100) ? 32'd100 : 32'd22})
            $display("FAIL fwd_exmem: got OP1=%0d OP2=%0d, want OP1=%0d", OP1, OP2, exp_both);
        else n_pass++;
        ExMemRegWrite = 0;
        tick();
        n_checks++;
        if ({OP1, OP2} !== {exp_wb1, exp_wb2})
            $display("FAIL fwd_memwb: got OP1=%0d OP2=%0d, want %0d %0d", OP1, OP2, exp_wb1, exp_wb2);
        else n_pass++;
        Rs = 5'd0; Rt = 5'd0; RD1 = 32'd55; RD2 = 32'd66;
        ExMemRegWrite = 1; ExMemRd = 5'd0; ExMemRes = 32'd123;
        MemWbRd = 5'd0;
        tick();
        n_checks++;
        if ({OP1, OP2} !== 64'd0)
            $display("FAIL fwd_x0: got OP1=%0d OP2=%0d, want 0 0", OP1, OP2);
        else n_pass++;
    endtask

    task automatic test_load_use();
        logic [31:0] exp_op1;
        clear_inputs();
        tick();
        // load x5 <- mem[x1]
        InValid = 1; MemReadIn = 1; RegWriteIn = 1; RdIn = 5'd5; Rs = 5'd1; Rt = 5'd2;
        ALUSrc = 1; RD1 = 32'd40;
        tick();
        // dependent instruction reads x5 as Rs
        MemReadIn = 0; RdIn = 5'd8; Rs = 5'd5; Rt = 5'd6; ALUSrc = 0;
        RD1 = 32'hDEAD; RD2 = 32'd3; ALUSelIn = 4'b0110;
        #1;
        n_checks++;
        if (LoadUseStall !== 1'b1)
            $display("FAIL lus_rs_detect: got %b, want 1", LoadUseStall);
        else n_pass++;
        tick();
        n_checks++;
        if ({OutValid, RegWrite, MemRead, OP1, Rd} !== '0)
            $display("FAIL lus_bubble: got V=%b RW=%b MR=%b OP1=%h Rd=%0d, want all 0",
                     OutValid, RegWrite, MemRead, OP1, Rd);
        else n_pass++;
        // load result now reaches EX/MEM
        ExMemRegWrite = 1; ExMemRd = 5'd5; ExMemRes = 32'h1234;
        #1;
        n_checks++;
        if (LoadUseStall !== 1'b0)
            $display("FAIL lus_single_bubble: got %b, want 0", LoadUseStall);
        else n_pass++;
`ifdef OPERAND_FWD_EN
        exp_op1 = 32'h1234;
`else
        exp_op1 = 32'hDEAD;
`endif
        tick();
        n_checks++;
        if ({OutValid, RegWrite, Rd, OP1, OP2} !== {1'b1, 1'b1, 5'd8, exp_op1, 32'd3})
            $display("FAIL lus_replay: got V=%b RW=%b Rd=%0d OP1=%h OP2=%h, want 1 1 8 %h 3",
                     OutValid, RegWrite, Rd, OP1, OP2, exp_op1);
        else n_pass++;
        // second load x5, then Rt-only dependency with and without immediate
        ExMemRegWrite = 0; MemReadIn = 1; RdIn = 5'd5; Rs = 5'd1; Rt = 5'd2;
        tick();
        MemReadIn = 0; RdIn = 5'd9; Rs = 5'd1; Rt = 5'd5; ALUSrc = 1;
        #1;
        n_checks++;
        if (LoadUseStall !== 1'b0)
            $display("FAIL lus_rt_imm: got %b, want 0", LoadUseStall);
        else n_pass++;
        ALUSrc = 0;
        #1;
        n_checks++;
        if (LoadUseStall !== 1'b1)
            $display("FAIL lus_rt_reg: got %b, want 1", LoadUseStall);
        else n_pass++;
        InValid = 0;
        #1;
        n_checks++;
        if (LoadUseStall !== 1'b0)
            $display("FAIL lus_invalid: got %b, want 0", LoadUseStall);
        else n_pass++;
    endtask

    task automatic test_stall();
        clear_inputs();
        tick();
        InValid = 1; RD1 = 32'd1; RD2 = 32'd2; Rs = 5'd1; Rt = 5'd2; ALUSelIn = 4'd3;
        RdIn = 5'd4; RegWriteIn = 1; MemReadIn = 1;
        tick();
        Stall = 1; Rs = 5'd4; RD1 = 32'd99; ALUSelIn = 4'd5; RdIn = 5'd9; MemReadIn = 0;
        #1;
        n_checks++;
        if (LoadUseStall !== 1'b1)
            $display("FAIL stall_lus_report: got %b, want 1", LoadUseStall);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            tick();
            RD1 = RD1 + 32'd1; RD2 = RD2 + 32'd7; RdIn = RdIn + 5'd1;
            n_checks++;
            if ({OP1, OP2, ALUSel, Rd, RegWrite, MemRead, OutValid} !== {32'd1, 32'd2, 4'd3, 5'd4, 1'b1, 1'b1, 1'b1})
                $display("FAIL stall_hold_%0d: got OP1=%0d OP2=%0d ALUSel=%0d Rd=%0d RW=%b MR=%b V=%b, want 1 2 3 4 1 1 1",
                         i, OP1, OP2, ALUSel, Rd, RegWrite, MemRead, OutValid);
            else n_pass++;
        end
        Flush = 1;
        tick();
        n_checks++;
        if ({OP1, OP2, ALUSel, Rd, RegWrite, MemRead, OutValid, LoadUseStall} !== '0)
            $display("FAIL stall_flush: got OP1=%0d OP2=%0d ALUSel=%0d Rd=%0d RW=%b MR=%b V=%b LUS=%b, want all 0",
                     OP1, OP2, ALUSel, Rd, RegWrite, MemRead, OutValid, LoadUseStall);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        clear_inputs();
        tick();
        InValid = 1; RD1 = 32'd77; RD2 = 32'd88; Rs = 5'd1; Rt = 5'd2; RdIn = 5'd3;
        RegWriteIn = 1; ALUSelIn = 4'd1;
        tick();
        n_checks++;
        if (OutValid !== 1'b1 || OP1 !== 32'd77)
            $display("FAIL midreset_pre: got V=%b OP1=%0d, want 1 77", OutValid, OP1);
        else n_pass++;
        Stall = 1; Flush = 1; reset = 1;
        tick();
        n_checks++;
        if ({OP1, OP2, ALUSel, Rd, RegWrite, MemRead, OutValid} !== '0)
            $display("FAIL midreset_clear: got OP1=%0d OP2=%0d ALUSel=%0d Rd=%0d RW=%b MR=%b V=%b, want all 0",
                     OP1, OP2, ALUSel, Rd, RegWrite, MemRead, OutValid);
        else n_pass++;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_capture();
        test_forward();
        test_load_use();
        test_stall();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
